// File: rtl/field_fetcher.sv
// Variable-length field fetcher for the unaligned-window byte memory.
// Walks a byte region and returns 1..4 byte right-aligned fields over valid/ready.
module field_fetcher #(
  parameter int MEM_BYTES = 512,
  parameter int GUARD     = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [8:0]  base_addr,
  input  logic [9:0]  byte_count,
  output logic [8:0]  mem_addr,
  input  logic [31:0] mem_data,
  input  logic        req_valid,
  input  logic [2:0]  req_len,
  output logic        req_ready,
  output logic        rsp_valid,
  output logic [31:0] rsp_data,
  input  logic        rsp_ready,
  output logic        busy,
  output logic        done,
  output logic        err
);

  typedef enum logic [1:0] {IDLE, RUN, DONE, ERR} state_t;

  state_t      state, state_nxt;
  logic [8:0]  ptr;
  logic [9:0]  remaining;
  logic [9:0]  rem_nxt;
  logic [10:0] region_end;
  logic        go, region_bad, acc, len_ok, take;
  logic [31:0] field;

  assign go         = start && (state != RUN);
  assign region_end = {2'b0, base_addr} + {1'b0, byte_count};
  assign region_bad = region_end > 11'(MEM_BYTES - GUARD);
  assign acc        = req_valid && req_ready;
  assign len_ok     = (req_len != 3'd0) && (req_len <= 3'd4) && ({7'b0, req_len} <= remaining);
  assign take       = acc && len_ok;
  assign rem_nxt    = remaining - {7'b0, req_len};
  assign mem_addr   = ptr;

  // Memory window is MSB-first, so the field is the top req_len bytes.
  always_comb begin
    field = mem_data;
    case (req_len)
      3'd1:    field = {24'b0, mem_data[31:24]};
      3'd2:    field = {16'b0, mem_data[31:16]};
      3'd3:    field = {8'b0,  mem_data[31:8]};
      default: field = mem_data;
    endcase
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next state
  always_comb begin
    state_nxt = state;
    case (state)
      RUN: begin
        if (acc && !len_ok)             state_nxt = ERR;
        else if (take && rem_nxt == '0) state_nxt = DONE;
      end
      default: begin
        if (go) begin
          if (region_bad)             state_nxt = ERR;
          else if (byte_count == '0)  state_nxt = DONE;
          else                        state_nxt = RUN;
        end
      end
    endcase
  end

  // Outputs
  always_comb begin
    busy      = (state == RUN);
    req_ready = (state == RUN) && (!rsp_valid || rsp_ready);
    done      = (state == DONE) && !rsp_valid;
  end

  // Datapath: pointer, count, one-entry response register, sticky error
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr       <= '0;
      remaining <= '0;
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
      err       <= 1'b0;
    end else if (go) begin
      ptr       <= base_addr;
      remaining <= byte_count;
      rsp_valid <= 1'b0;
      err       <= region_bad;
    end else begin
      if (take) begin
        ptr       <= ptr + {6'b0, req_len};
        remaining <= rem_nxt;
        rsp_data  <= field;
        rsp_valid <= 1'b1;
      end else if (rsp_valid && rsp_ready) begin
        rsp_valid <= 1'b0;
      end
      if (acc && !len_ok) err <= 1'b1;
    end
  end

endmodule
